// File: rtl/mul_pkg.sv
// Shared definitions for the 64x64 low-half multiplier datapath: operand
// width, Booth row count, Booth digit select encoding and its decoder.
package mul_pkg;

    localparam int MUL_WIDTH  = 64;
    localparam int MUL_NUM_PP = MUL_WIDTH / 2;

    // Radix-4 Booth digit selected by one 3-bit multiplier group.
    typedef enum logic [2:0] {
        BOOTH_ZERO,
        BOOTH_POS,
        BOOTH_NEG,
        BOOTH_POS2,
        BOOTH_NEG2
    } booth_sel_t;

    // Map {y[2k+1], y[2k], y[2k-1]} to the Booth digit it represents.
    function automatic booth_sel_t booth_decode(input logic [2:0] grp);
        booth_sel_t sel;
        case (grp)
            3'b001, 3'b010: sel = BOOTH_POS;
            3'b011:         sel = BOOTH_POS2;
            3'b100:         sel = BOOTH_NEG2;
            3'b101, 3'b110: sel = BOOTH_NEG;
            default:        sel = BOOTH_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One radix-4 Booth partial-product row. Negative digits are emitted as the
// ones-complement of the magnitude plus a separate +1 carry-in bit, so the
// downstream compressor absorbs the increment instead of a carry chain here.
module booth_pp_row
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2:0]       i_group,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_row,
    output logic             o_carry
);

    booth_sel_t       w_sel;
    logic [WIDTH-1:0] w_x2;

    assign w_sel = booth_decode(i_group);
    // 2x is a left shift; the bit shifted out is beyond the low product half.
    assign w_x2  = {i_x[WIDTH-2:0], 1'b0};

    // Select the row value and correction bit for this digit.
    always_comb begin
        o_row   = '0;
        o_carry = 1'b0;
        case (w_sel)
            BOOTH_POS:  o_row = i_x;
            BOOTH_NEG: begin
                o_row   = ~i_x;
                o_carry = 1'b1;
            end
            BOOTH_POS2: o_row = w_x2;
            BOOTH_NEG2: begin
                o_row   = ~w_x2;
                o_carry = 1'b1;
            end
            default: begin
                o_row   = '0;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_pp_gen_stage.sv
// Two-register Booth partial-product stage feeding the Wallace compressor.
// S1 holds the operand pair, the 32 row generators sit between S1 and S2,
// and S2 holds the full row bundle presented to the compressor.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; ready never depends on valid on the same side, valid/data are held
// stable by the producer until the transfer, and flush kills both stages
// while refusing any input offered in that cycle.
module booth_pp_gen_stage
    import mul_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int TAG_W  = 4,
    localparam int NUM_PP = WIDTH / 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_x,
    input  logic [WIDTH-1:0]        in_y,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_PP*WIDTH-1:0] out_pp,
    output logic [NUM_PP-1:0]       out_carry,
    output logic [TAG_W-1:0]        out_tag
);

    if (WIDTH != MUL_WIDTH) begin : g_width_check
        $error("booth_pp_gen_stage: only WIDTH=64 is supported");
    end

    logic                    r_s1_valid;
    logic [WIDTH-1:0]        r_x;
    logic [WIDTH-1:0]        r_y;
    logic [TAG_W-1:0]        r_s1_tag;
    logic                    r_s2_valid;
    logic [NUM_PP*WIDTH-1:0] r_pp;
    logic [NUM_PP-1:0]       r_carry;
    logic [TAG_W-1:0]        r_s2_tag;

    logic                    w_s1_adv;
    logic                    w_in_fire;
    logic                    w_s1_fire;
    logic [WIDTH:0]          w_y_ext;
    logic [NUM_PP*WIDTH-1:0] w_pp;
    logic [NUM_PP-1:0]       w_carry;

    // S1 may move forward whenever S2 is empty or being drained this cycle.
    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = (!r_s1_valid || w_s1_adv) && !flush;
    assign w_in_fire = in_valid && in_ready;
    assign w_s1_fire = r_s1_valid && w_s1_adv;

    // Appending y[-1]=0 makes every group a plain 3-bit slice.
    assign w_y_ext = {r_y, 1'b0};

    for (genvar k = 0; k < NUM_PP; k++) begin : g_row
        booth_pp_row #(
            .WIDTH (WIDTH)
        ) u_row (
            .i_group (w_y_ext[2*k+2 -: 3]),
            .i_x     (r_x),
            .o_row   (w_pp[k*WIDTH +: WIDTH]),
            .o_carry (w_carry[k])
        );
    end

    // S1 valid: set on accept, cleared when it moves on, killed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S1 operand registers load only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_s1_tag <= '0;
        end else if (w_in_fire) begin
            r_x      <= in_x;
            r_y      <= in_y;
            r_s1_tag <= in_tag;
        end
    end

    // S2 valid: refilled from S1, cleared when consumed, killed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_fire) begin
            r_s2_valid <= 1'b1;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // S2 row registers hold steady unless S1 advances into them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pp     <= '0;
            r_carry  <= '0;
            r_s2_tag <= '0;
        end else if (w_s1_fire) begin
            r_pp     <= w_pp;
            r_carry  <= w_carry;
            r_s2_tag <= r_s1_tag;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_pp    = r_pp;
    assign out_carry = r_carry;
    assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_booth_pp_gen_stage.sv
// Self-checking bench for booth_pp_gen_stage: directed Booth corner cases,
// random back-to-back traffic, random backpressure, flush and async reset.
module tb_booth_pp_gen_stage;

  localparam int W      = 64;
  localparam int TAG_W  = 4;
  localparam int NUM_PP = W / 2;
  localparam int EW     = TAG_W + 2 * W;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_x;
  logic [W-1:0]         in_y;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_PP*W-1:0]  out_pp;
  logic [NUM_PP-1:0]    out_carry;
  logic [TAG_W-1:0]     out_tag;

  booth_pp_gen_stage #(
    .WIDTH (W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pp    (out_pp),
    .out_carry (out_carry),
    .out_tag   (out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]       exp_q[$];   // {tag, x, y} of every accepted op, oldest first
  int                  cap_q[$];   // edge index at which each op was captured
  int                  cyc;
  int                  n_cmp;
  int                  n_err;
  int                  n_acc;
  logic                last_acc;
  logic [TAG_W-1:0]    tag_ctr;
  logic                hold_v;
  logic [NUM_PP*W-1:0] hold_pp;
  logic [NUM_PP-1:0]   hold_carry;
  logic [TAG_W-1:0]    hold_tag;
  logic [W-1:0]        last_row0;
  logic [W-1:0]        last_row1;
  logic [NUM_PP-1:0]   last_carry;
  logic [W-1:0]        last_sum;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: Booth digit d = -2*y[2k+1] + y[2k] + y[2k-1] as an integer;
  // the row is |d|*x, ones-complemented with a +1 carry when d is negative.
  function automatic void model_row(input logic [W-1:0] x, input logic [W-1:0] y, input int k,
                                    output logic [W-1:0] row, output logic c);
    int d;
    logic [W-1:0] m;
    d = -2 * int'(y[2*k+1]) + int'(y[2*k]) + ((k == 0) ? 0 : int'(y[2*k-1]));
    m = x * W'(d < 0 ? -d : d);
    if (d < 0) begin
      row = ~m;
      c   = 1'b1;
    end else begin
      row = m;
      c   = 1'b0;
    end
  endfunction

  // Compare the presented bundle against the oldest expected op.
  task automatic check_bundle();
    logic [EW-1:0]    e;
    logic [TAG_W-1:0] e_tag;
    logic [W-1:0]     ex, ey, row, r_obs, sum;
    logic             c;
    e     = exp_q[0];
    e_tag = e[EW-1 -: TAG_W];
    ex    = e[2*W-1 -: W];
    ey    = e[W-1:0];
    check_eq("tag", W'(out_tag), W'(e_tag));
    sum = '0;
    for (int k = 0; k < NUM_PP; k++) begin
      model_row(ex, ey, k, row, c);
      r_obs = out_pp[k*W +: W];
      check_eq($sformatf("row%0d", k), r_obs, row);
      check_eq($sformatf("carry%0d", k), W'(out_carry[k]), W'(c));
      sum = sum + ((r_obs + W'(out_carry[k])) << (2 * k));
    end
    check_eq("weighted_sum", sum, ex * ey);
    last_row0  = out_pp[W-1:0];
    last_row1  = out_pp[2*W-1:W];
    last_carry = out_carry;
    last_sum   = sum;
  endtask

  // Called at a negedge with inputs already driven; checks, then crosses one edge.
  task automatic step();
    logic exp_ready, exp_valid, fire_in, fire_out;
    #1;
    exp_ready = !flush && (exp_q.size() < 2 || out_ready);
    exp_valid = (exp_q.size() > 0) && (cyc - cap_q[0] >= 1);
    check_eq("in_ready", W'(in_ready), W'(exp_ready));
    check_eq("out_valid", W'(out_valid), W'(exp_valid));
    if (hold_v) begin
      check_eq("stall_tag", W'(out_tag), W'(hold_tag));
      check_eq("stall_carry", W'(out_carry), W'(hold_carry));
      check_eq("stall_pp", W'(out_pp == hold_pp), W'(1'b1));
    end
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    if (fire_out && !flush && exp_q.size() > 0) check_bundle();
    hold_v = out_valid && !out_ready && !flush;
    if (hold_v) begin
      hold_pp    = out_pp;
      hold_carry = out_carry;
      hold_tag   = out_tag;
    end
    @(posedge clk);
    cyc++;
    last_acc = 1'b0;
    if (flush) begin
      exp_q.delete();
      cap_q.delete();
    end else begin
      if (fire_out && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(cap_q.pop_front());
      end
      if (fire_in) begin
        exp_q.push_back({in_tag, in_x, in_y});
        cap_q.push_back(cyc);
        n_acc++;
        last_acc = 1'b1;
        tag_ctr  = tag_ctr + 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand64();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Send one op and drain it with out_ready held high.
  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_tag    = tag_ctr;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    check_eq("drain_timeout", W'(exp_q.size()), '0);
  endtask

  // Pull reset mid-cycle and confirm outputs clear without a clock edge.
  task automatic reset_mid();
    #3;
    rst_n = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("rst_out_valid", W'(out_valid), '0);
    check_eq("rst_out_pp", W'(|out_pp), '0);
    check_eq("rst_out_carry", W'(out_carry), '0);
    check_eq("rst_out_tag", W'(out_tag), '0);
    check_eq("rst_in_ready", W'(in_ready), W'(1'b1));
    exp_q.delete();
    cap_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    n_cmp = 0; n_err = 0; n_acc = 0; cyc = 0;
    tag_ctr = '0; hold_v = 1'b0; last_acc = 1'b0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_out_valid", W'(out_valid), '0);
    check_eq("reset_out_pp", W'(|out_pp), '0);
    check_eq("reset_out_carry", W'(out_carry), '0);
    check_eq("reset_out_tag", W'(out_tag), '0);
    check_eq("reset_in_ready", W'(in_ready), W'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed Booth cases.
    run_one(64'd3, 64'd5);
    check_eq("d35_row0", last_row0, 64'd3);
    check_eq("d35_row1", last_row1, 64'd3);
    check_eq("d35_carry", W'(last_carry), '0);
    check_eq("d35_sum", last_sum, 64'd15);

    run_one(64'd7, '1);
    check_eq("d7m1_row0", last_row0, 64'hFFFF_FFFF_FFFF_FFF8);
    check_eq("d7m1_carry", W'(last_carry), 64'd1);
    check_eq("d7m1_sum", last_sum, 64'hFFFF_FFFF_FFFF_FFF9);

    run_one(64'h8000_0000_0000_0000, 64'd2);
    check_eq("dmin2_row0", last_row0, '1);
    check_eq("dmin2_carry", W'(last_carry), 64'd1);
    check_eq("dmin2_sum", last_sum, '0);

    run_one(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
    run_one({$urandom, $urandom}, 64'h7FFF_FFFF_FFFF_FFFF);

    // 1000 back-to-back ops with the compressor always ready.
    n_acc     = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = 1'b1;
    guard     = 0;
    while (n_acc < 1000 && guard < 1200) begin
      if (last_acc) begin
        in_x   = rand64();
        in_y   = rand64();
        in_tag = tag_ctr;
      end
      step();
      guard++;
    end
    check_eq("b2b_accepted", W'(n_acc), W'(1000));
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    check_eq("b2b_drain", W'(exp_q.size()), '0);

    // Fill both stages while stalled, then flush with input offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_x   = rand64();
      in_y   = rand64();
      in_tag = tag_ctr;
      step();
    end
    check_eq("full_before_flush", W'(exp_q.size()), W'(2));
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // Random traffic with random backpressure and a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_mid();
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_x     = rand64();
        in_y     = rand64();
        in_tag   = tag_ctr;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    check_eq("random_drain", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
